// File: rtl/output_requant_writeback.sv
// Output requantization and BRAM writeback.
// Accumulator rows are rounded, shifted, optionally ReLU'd and saturated to
// int8 per lane, packed into one word, and queued in a small FIFO so that
// write-port stalls never back-pressure the output buffer.
module output_requant_writeback #(
  parameter int LANES      = 8,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 11
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [LANES*ACC_W-1:0]   in_data_i,
  input  logic                     in_last_i,
  input  logic [2:0]               tile_row_idx_i,
  input  logic [4:0]               tile_col_idx_i,
  input  logic                     relu_en_i,
  input  logic [4:0]               shift_amt_i,
  output logic                     wr_valid_o,
  input  logic                     wr_ready_i,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [LANES*8-1:0]       wr_data_o,
  output logic                     busy_o,
  output logic                     tile_done_o,
  output logic                     overflow_o
);

  localparam int RW = $clog2(LANES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-128);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [LANES*8-1:0] data;
  } wr_entry_t;

  state_e                     state_q;
  logic [RW-1:0]              row_cnt_q;
  logic [2:0]                 tile_row_q;
  logic [4:0]                 tile_col_q;
  logic                       tile_done_q;
  logic                       overflow_q;

  logic                       s1_vld_q;
  logic                       s1_relu_q;
  logic [RW-1:0]              s1_row_q;
  logic [LANES-1:0][ACC_W:0]  s1_r_d, s1_r_q;
  logic [LANES*8-1:0]         s2_data;
  wr_entry_t                  s2_entry;

  wr_entry_t                  mem_q [FIFO_DEPTH];
  logic [PW-1:0]              rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]              cnt_q, cnt_d;

  logic accept, fifo_full, fifo_empty, push, pop, drop, drain_done;
  logic [RW-1:0] beat_row, row_nxt;

  // Rows are only taken while a tile is open; the first beat always uses row 0.
  assign accept   = in_valid_i && (state_q != DRAIN);
  assign beat_row = (state_q == IDLE) ? '0 : row_cnt_q;
  assign row_nxt  = (beat_row == RW'(LANES-1)) ? '0 : beat_row + RW'(1);

  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = !fifo_empty && wr_ready_i;
  assign push       = s1_vld_q && (!fifo_full || pop);
  assign drop       = s1_vld_q && fifo_full && !pop;
  // Final word leaves while nothing is behind it in the pipe or FIFO.
  assign drain_done = !s1_vld_q && (cnt_q == CW'(1)) && pop;

  // Per-lane datapath: S1 rounds and shifts in ACC_W+1 bits, S2 clamps and packs.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [ACC_W:0] x_ext, rnd, sum, r, rr;
    logic [7:0]            q;

    assign x_ext = $signed({in_data_i[ACC_W*g+ACC_W-1], in_data_i[ACC_W*g +: ACC_W]});
    assign rnd   = (shift_amt_i == 5'd0) ? '0
                 : $signed((ACC_W+1)'(1) << (shift_amt_i - 5'd1));
    assign sum   = x_ext + rnd;
    assign s1_r_d[g] = sum >>> shift_amt_i;

    assign r  = $signed(s1_r_q[g]);
    assign rr = (s1_relu_q && r[ACC_W]) ? '0 : r;

    // Saturate the clamped value into int8.
    always_comb begin
      q = rr[7:0];
      if (rr > SAT_MAX)      q = 8'h7F;
      else if (rr < SAT_MIN) q = 8'h80;
    end

    assign s2_data[8*g +: 8] = q;
  end

  assign s2_entry = '{addr: {tile_row_q, tile_col_q, s1_row_q}, data: s2_data};

  // S1 pipeline register: rounded/shifted lanes plus the row's tag bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q  <= 1'b0;
      s1_relu_q <= 1'b0;
      s1_row_q  <= '0;
      s1_r_q    <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_relu_q <= relu_en_i;
        s1_row_q  <= beat_row;
        s1_r_q    <= s1_r_d;
      end
    end
  end

  // Tile FSM: capture indices, count rows, and close the tile once the last word is written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      tile_row_q  <= '0;
      tile_col_q  <= '0;
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      case (state_q)
        IDLE: if (in_valid_i) begin
          tile_row_q <= tile_row_idx_i;
          tile_col_q <= tile_col_idx_i;
          if (in_last_i) begin
            state_q   <= DRAIN;
            row_cnt_q <= '0;
          end else begin
            state_q   <= COLLECT;
            row_cnt_q <= row_nxt;
          end
        end
        COLLECT: if (in_valid_i) begin
          if (in_last_i) begin
            state_q   <= DRAIN;
            row_cnt_q <= '0;
          end else begin
            row_cnt_q <= row_nxt;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q     <= IDLE;
            tile_done_q <= 1'b1;
          end else if (!s1_vld_q && fifo_empty) begin
            // Nothing left to write (every remaining row was dropped).
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky overflow: a row lost to a full FIFO or arriving during drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                       overflow_q <= 1'b0;
    else if (drop || (in_valid_i && state_q == DRAIN)) overflow_q <= 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // Write FIFO; head entry drives the BRAM port and holds while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= s2_entry;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign wr_valid_o  = !fifo_empty;
  assign wr_addr_o   = mem_q[rd_ptr_q].addr;
  assign wr_data_o   = mem_q[rd_ptr_q].data;
  assign busy_o      = (state_q != IDLE);
  assign tile_done_o = tile_done_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_output_requant_writeback.sv
// Directed bench for output_requant_writeback: table of single-row
// requant vectors plus hand-written tile, backpressure and reset sequences.
module tb_output_requant_writeback;
  localparam int LANES = 8, ACC_W = 32, FIFO_DEPTH = 4, ADDR_W = 11;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0, in_last = 1'b0, relu_en = 1'b0, wr_ready = 1'b0;
  logic [LANES*ACC_W-1:0] in_data = '0;
  logic [2:0]             tile_row = '0;
  logic [4:0]             tile_col = '0, shift_amt = '0;
  logic                   wr_valid, busy, tile_done, overflow;
  logic [ADDR_W-1:0]      wr_addr;
  logic [LANES*8-1:0]     wr_data;

  always #5 clk = ~clk;

  output_requant_writeback #(.LANES(LANES), .ACC_W(ACC_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last),
    .tile_row_idx_i(tile_row), .tile_col_idx_i(tile_col), .relu_en_i(relu_en), .shift_amt_i(shift_amt),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .tile_done_o(tile_done), .overflow_o(overflow));

  typedef struct packed {
    logic [4:0]   shift;
    logic         relu;
    logic [255:0] x;
    logic [63:0]  e;
  } vec_t;

  vec_t vecs [6];
  int   total = 0, bad = 0;
  int   cyc = 0, hs_cyc = 0, done_cnt = 0;
  logic [ADDR_W+63:0] wq [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every accepted write and every tile_done pulse.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      wq.push_back({wr_addr, wr_data});
      hs_cyc = cyc;
    end
    if (tile_done) done_cnt++;
  end

  function automatic logic [255:0] pk32(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {32'(a7), 32'(a6), 32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [63:0] pk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a tile_done pulse at a negedge; reports cycle seen.
  task automatic wait_done(input string nm, output int at_cyc);
    bit ok = 0;
    at_cyc = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tile_done) begin
        ok = 1;
        at_cyc = cyc;
        break;
      end
    end
    chk(nm, 128'(ok), 128'(1));
  endtask

  initial begin
    int dc, dc0;
    logic [255:0] d;
    logic [63:0]  e;
    logic [ADDR_W+63:0] ref_w, got_w;
    bit stable;

    vecs[0] = '{5'd0, 1'b0, pk32(5, -3, 127, -128, 0, 1, -1, 64), pk8(5, -3, 127, -128, 0, 1, -1, 64)};
    vecs[1] = '{5'd4, 1'b0, pk32('h18, 'h7FFFFFFF, 'hFFFFFF00, -40000, 0, 7, 8, -8),
                pk8(2, 127, -16, -128, 0, 0, 1, 0)};
    vecs[2] = '{5'd0, 1'b1, pk32(-5, 7, -1, 0, 200, -200, 100, -100), pk8(0, 7, 0, 0, 127, 0, 100, 0)};
    vecs[3] = '{5'd0, 1'b0, pk32(-5, 7, -1, 0, 200, -200, 100, -100), pk8(-5, 7, -1, 0, 127, -128, 100, -100)};
    vecs[4] = '{5'd31, 1'b0, pk32('h7FFFFFFF, 'h80000000, 'h40000000, 'hC0000000, 'h3FFFFFFF, -1, 1, 0),
                pk8(1, -1, 1, 0, 0, 0, 0, 0)};
    vecs[5] = '{5'd1, 1'b0, pk32(3, -3, 1, -1, 255, -255, 256, -257), pk8(2, -1, 1, 0, 127, -127, 127, -128)};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_valid", 128'(wr_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done_ovf", 128'({tile_done, overflow}), 128'(0));
    chk("rst_addr_data", 128'({wr_addr, wr_data}), 128'(0));
    rst_n = 1'b1;
    wr_ready = 1'b1;

    // Single-row tiles from the vector table
    for (int i = 0; i < 6; i++) begin
      tick();
      in_valid = 1'b1; in_last = 1'b1; in_data = vecs[i].x;
      shift_amt = vecs[i].shift; relu_en = vecs[i].relu;
      tile_row = 3'(i + 1); tile_col = 5'(3 * i + 5);
      tick();
      in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      @(negedge clk);
      chk($sformatf("v%0d_lat_t1", i), 128'(wr_valid), 128'(0));
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_lat_t2", i), 128'(wr_valid), 128'(1));
      chk($sformatf("v%0d_data", i), 128'(wr_data), 128'(vecs[i].e));
      chk($sformatf("v%0d_addr", i), 128'(wr_addr), 128'({3'(i + 1), 5'(3 * i + 5), 3'd0}));
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_done", i), 128'({tile_done, busy}), 128'(2'b10));
    end
    shift_amt = '0; relu_en = 1'b0;

    // 8-row tile, row=2 col=9, ready held high
    tick();
    wq.delete();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < LANES; i++) d[32*i +: 32] = 32'(k * 8 + i);
      in_valid = 1'b1; in_last = (k == 7); in_data = d;
      tile_row = 3'd2; tile_col = 5'd9;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("tile_busy", 128'(busy), 128'(1));
    wait_done("tile_done_seen", dc);
    chk("tile_nwrites", 128'(wq.size()), 128'(8));
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < LANES; i++) e[8*i +: 8] = 8'(k * 8 + i);
      got_w = (k < wq.size()) ? wq[k] : 'x;
      chk($sformatf("tile_w%0d", k), 128'(got_w), 128'({11'h248 + 11'(k), e}));
    end
    chk("tile_done_lat", 128'(dc - hs_cyc), 128'(1));
    tick();
    @(negedge clk);
    chk("tile_after", 128'({busy, tile_done, overflow}), 128'(0));

    // Backpressure: ready low for 10 cycles starting at row 4's beat
    tick();
    wq.delete();
    stable = 1'b1;
    ref_w = '0;
    for (int k = 0; k < 14; k++) begin
      if (k == 4) wr_ready = 1'b0;
      if (k < 8) begin
        for (int i = 0; i < LANES; i++) d[32*i +: 32] = 32'(k * 10 + i - 20);
        in_valid = 1'b1; in_last = (k == 7); in_data = d;
        tile_row = 3'd5; tile_col = 5'd17;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      @(negedge clk);
      if (k == 4) ref_w = {wr_addr, wr_data};
      else if (k > 4 && (!wr_valid || {wr_addr, wr_data} !== ref_w)) stable = 1'b0;
      tick();
    end
    wr_ready = 1'b1;
    chk("bp_stall_stable", 128'(stable), 128'(1));
    chk("bp_stall_head", 128'(ref_w[ADDR_W+63:64]), 128'({3'd5, 5'd17, 3'd2}));
    wait_done("bp_done_seen", dc);
    chk("bp_nwrites", 128'(wq.size()), 128'(6));
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < LANES; i++) e[8*i +: 8] = 8'(k * 10 + i - 20);
      got_w = (k < wq.size()) ? wq[k] : 'x;
      chk($sformatf("bp_w%0d", k), 128'(got_w), 128'({3'd5, 5'd17, 3'(k), e}));
    end
    chk("bp_overflow", 128'(overflow), 128'(1));

    // Async reset mid-tile with the FIFO holding rows
    tick();
    wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_last = 1'b0; in_data = '1;
      tile_row = 3'd1; tile_col = 5'd1;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("mr_pre", 128'({wr_valid, busy}), 128'(2'b11));
    @(posedge clk);
    #3;
    dc0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mr_wr_valid", 128'(wr_valid), 128'(0));
    chk("mr_busy_ovf", 128'({busy, overflow}), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    repeat (4) tick();
    chk("mr_no_done", 128'(done_cnt - dc0), 128'(0));

    // Next tile restarts at row 0
    wq.delete();
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_last = (k == 1); in_data = pk32(k, k, k, k, k, k, k, k);
      tile_row = 3'd6; tile_col = 5'd30;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_done("post_done_seen", dc);
    chk("post_nwrites", 128'(wq.size()), 128'(2));
    got_w = (wq.size() > 0) ? wq[0] : 'x;
    chk("post_w0", 128'(got_w), 128'({3'd6, 5'd30, 3'd0, pk8(0, 0, 0, 0, 0, 0, 0, 0)}));
    got_w = (wq.size() > 1) ? wq[1] : 'x;
    chk("post_w1", 128'(got_w), 128'({3'd6, 5'd30, 3'd1, pk8(1, 1, 1, 1, 1, 1, 1, 1)}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
